dcache_req_port: RTL and testbench
==================================

# dcache_req_port

MEM-stage data-side request issuer for the 7-stage LA32 pipeline: accepts load/store operations from EX and drives an SRAM-like bus (req/addr_ok/data_ok). It tracks outstanding transactions, turns an exception flush into a count of stale responses to drop, and buffers in-order responses while WB stalls. It is the issuing end of the response-cancel and buffering scheme used on the consuming side of the cache interface.

## Interface
- MAX_OUTST, 2, max address-accepted-but-unanswered transactions, legal 1..3; response buffer depth equals MAX_OUTST
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid_i  in  1  EX holds a valid memory op
- ex_wr_i  in  1  1 = store
- ex_size_i  in  2  0 = byte, 1 = half, 2 = word
- ex_wstrb_i  in  4  byte strobes
- ex_addr_i  in  ADDR_W  address
- ex_wdata_i  in  DATA_W  store data
- mem_allowin_o  out  1  EX op is accepted this cycle when ex_valid_i is also high
- req_o, wr_o, size_o, wstrb_o, addr_o, wdata_o  out  1/1/2/4/ADDR_W/DATA_W  bus request, all registered
- addr_ok_i  in  1  request handshake (req_o && addr_ok_i)
- data_ok_i  in  1  one in-order response
- rdata_i  in  DATA_W  response data
- excep_flush_i  in  1  exception/ertn flush
- wb_allowin_i  in  1  WB takes rsp this cycle
- rsp_valid_o  out  1  non-stale response available
- rsp_rdata_o  out  DATA_W  response data, undefined for stores

## Operation
- Request FSM states: IDLE, REQ, REQ_CANCEL.
  - IDLE -> REQ on accept: ex_valid_i && mem_allowin_o && !excep_flush_i. Bus fields latch EX fields.
  - REQ: req_o=1. All fields are held stable until the handshake. On handshake, go to IDLE and increment outst_cnt.
  - REQ + excep_flush_i without handshake -> REQ_CANCEL. The request cannot be retracted: req_o stays high until addr_ok_i.
  - REQ_CANCEL: on handshake, go to IDLE; outst_cnt++ and cancel_cnt++.
  - REQ + flush + handshake in the same cycle: the request counts as cancelled.
- mem_allowin_o = state==IDLE && (outst_cnt + buf_cnt) < MAX_OUTST && rst_n. It is forced to 0 while rst_n=0.
- Counters are 2 bits wide and saturate only by design; overflow is an assertion failure.
  - outst_cnt: +1 on handshake, -1 on data_ok_i; a simultaneous +1 and -1 nets to zero.
  - cancel_cnt ≤ outst_cnt.
- Each data_ok_i with cancel_cnt>0 (value before this cycle) is discarded and cancel_cnt decrements.
- Flush: cancel_cnt <= outst_cnt_next. This counts every unanswered transaction, including one accepted in the flush cycle, and excludes a data_ok_i in the flush cycle, which is itself discarded. The flush also empties the response buffer.
- Response buffer: FIFO of MAX_OUTST entries of DATA_W.
  - Push a kept response when it cannot bypass (see Configuration).
  - Pop when wb_allowin_i && buffer non-empty.
  - Buffered data is always presented before live rdata_i (in-order).
- Reset values: req_o=0, wr_o=0, size_o=0, wstrb_o=0, addr_o=0, wdata_o=0, state=IDLE, outst_cnt=0, cancel_cnt=0, buffer empty, rsp_valid_o=0, rsp_rdata_o=0, mem_allowin_o=0.
- Reset mid-transaction clears all state; the bus agent is reset in the same domain.

## Timing
- EX accept at edge N -> req_o=1 during cycle N+1. Back-to-back issue requires one IDLE cycle between requests (1 request / 2 cycles peak).
- data_ok_i is at earliest the cycle after the handshake.
- Bypass path: rsp_valid_o combinational from data_ok_i (0-cycle).
- Buffered path: rsp_valid_o from register, 1 cycle after data_ok_i.
- Flush takes effect at the flush edge: rsp_valid_o=0 during the flush cycle.

## Configuration
- DCACHE_RSP_BYPASS_EN defined:
  - rsp_valid_o = buf_nonempty || (data_ok_i && cancel_cnt==0 && !excep_flush_i).
  - rsp_rdata_o = buffer head if non-empty, else rdata_i.
  - Push only when the response is kept and (buffer non-empty || !wb_allowin_i).
- Not defined: every kept response is pushed; rsp_valid_o = buf_nonempty; +1 cycle latency; no combinational data_ok_i -> rsp_valid_o path.

## Test plan
- Load 0x1000: accept at edge 0; req_o=1 cycle 1; addr_ok cycle 1; data_ok cycle 3 with rdata 0xDEADBEEF, wb_allowin=1 -> rsp_valid_o=1 with 0xDEADBEEF in cycle 3 (bypass) / cycle 4 (no bypass).
- Two loads accepted while wb_allowin_i=0, responses 0x11 then 0x22 -> mem_allowin_o=0 after the second handshake. Release wb -> 0x11 then 0x22 on consecutive cycles.
- Two outstanding loads, flush -> cancel_cnt=2. Both data_ok_i dropped (rsp_valid_o stays 0). A third load issued after the flush returns 0x33 normally.
- Flush while req_o high and addr_ok_i low for 3 cycles -> req_o/addr_o unchanged until addr_ok_i; that response is discarded; mem_allowin_o=0 until IDLE.
- Flush in the same cycle as data_ok_i (outst_cnt=2) -> that response dropped; cancel_cnt=1; next response dropped; buffer empty.
- rst_n=0 mid-REQ with buffer holding 1 entry -> next cycle all outputs at reset values, buffer empty, mem_allowin_o=1 after rst_n=1.

Source files
------------

// File: rtl/dcache_req_port.sv
// dcache_req_port: MEM-stage data-side request issuer for the LA32 pipeline.
// Drives an SRAM-like bus (req/addr_ok/data_ok), counts outstanding
// transactions, converts an exception flush into a count of stale responses
// to drop, and buffers in-order responses while WB stalls.
// Optional feature macro: DCACHE_RSP_BYPASS_EN (0-cycle response bypass).
// Without it every kept response passes through the buffer (+1 cycle).

// Invariant checker for the counters and buffer occupancy.
module dcache_req_port_chk #(
   parameter int MAX_OUTST = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hs,
   input  logic       data_ok,
   input  logic [1:0] outst_cnt,
   input  logic [1:0] cancel_cnt,
   input  logic [1:0] buf_cnt
);
   // outstanding counter never wraps upward
   assert property (@(posedge clk) disable iff (!rst_n)
      !(hs && !data_ok && (outst_cnt == 2'd3)));
   // a response never arrives with nothing outstanding
   assert property (@(posedge clk) disable iff (!rst_n)
      !(data_ok && (outst_cnt == 2'd0)));
   // stale responses are a subset of outstanding ones
   assert property (@(posedge clk) disable iff (!rst_n)
      (cancel_cnt <= outst_cnt));
   // outstanding plus buffered never exceeds the buffer depth
   assert property (@(posedge clk) disable iff (!rst_n)
      (({1'b0, outst_cnt} + {1'b0, buf_cnt}) <= 3'(MAX_OUTST)));
endmodule

module dcache_req_port #(
   parameter int MAX_OUTST = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid_i,
   input  logic              ex_wr_i,
   input  logic [1:0]        ex_size_i,
   input  logic [3:0]        ex_wstrb_i,
   input  logic [ADDR_W-1:0] ex_addr_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   output logic              mem_allowin_o,
   output logic              req_o,
   output logic              wr_o,
   output logic [1:0]        size_o,
   output logic [3:0]        wstrb_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o,
   input  logic              addr_ok_i,
   input  logic              data_ok_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              excep_flush_i,
   input  logic              wb_allowin_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REQ        = 2'd1,
      REQ_CANCEL = 2'd2
   } state_t;

   localparam logic [1:0] LAST_IDX    = 2'(MAX_OUTST - 1);
   localparam logic [2:0] MAX_OUTST_W = 3'(MAX_OUTST);

   // Circular pointer advance over MAX_OUTST buffer slots.
   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
      if (ptr == LAST_IDX) begin
         return 2'd0;
      end else begin
         return ptr + 2'd1;
      end
   endfunction

   state_t            state_r, state_next_s;
   logic              req_r, wr_r;
   logic [1:0]        size_r;
   logic [3:0]        wstrb_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;

   logic [1:0]        outst_cnt_r, outst_cnt_next_s;
   logic [1:0]        cancel_cnt_r, cancel_cnt_next_s;

   // Storage sized for the largest legal depth; only MAX_OUTST slots are used.
   logic [DATA_W-1:0] buf_mem_r [4];
   logic [1:0]        rd_ptr_r, wr_ptr_r, buf_cnt_r;

   logic hs_s, allowin_s, accept_s, buf_nonempty_s, keep_s;
   logic push_s, pop_s, rsp_valid_s;
   logic cancel_inc_s, cancel_dec_s;
   logic [DATA_W-1:0] rsp_rdata_s;

   assign hs_s           = req_r && addr_ok_i;
   assign allowin_s      = (state_r == IDLE) && rst_n &&
                           (({1'b0, outst_cnt_r} + {1'b0, buf_cnt_r}) < MAX_OUTST_W);
   assign accept_s       = ex_valid_i && allowin_s && !excep_flush_i;
   assign buf_nonempty_s = (buf_cnt_r != 2'd0);
   // A response is kept only if nothing stale is ahead of it and no flush now.
   assign keep_s         = rst_n && data_ok_i && (cancel_cnt_r == 2'd0) && !excep_flush_i;
   assign cancel_inc_s   = hs_s && (state_r == REQ_CANCEL);
   assign cancel_dec_s   = data_ok_i && (cancel_cnt_r != 2'd0);
   assign pop_s          = wb_allowin_i && buf_nonempty_s && !excep_flush_i;

   // Request FSM next state; a flush cannot retract a request already on the bus.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_next_s = REQ;
            end else begin
               state_next_s = IDLE;
            end
         end
         REQ: begin
            if (hs_s) begin
               state_next_s = IDLE;
            end else if (excep_flush_i) begin
               state_next_s = REQ_CANCEL;
            end else begin
               state_next_s = REQ;
            end
         end
         REQ_CANCEL: begin
            if (hs_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = REQ_CANCEL;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Outstanding and stale-response counter updates.
   always_comb begin
      outst_cnt_next_s  = outst_cnt_r;
      cancel_cnt_next_s = cancel_cnt_r;
      if (hs_s && !data_ok_i) begin
         outst_cnt_next_s = outst_cnt_r + 2'd1;
      end else if (!hs_s && data_ok_i) begin
         outst_cnt_next_s = outst_cnt_r - 2'd1;
      end else begin
         outst_cnt_next_s = outst_cnt_r;
      end
      // On flush every still-unanswered transaction becomes stale, including
      // one handshaken this very cycle; a response this cycle is itself dropped.
      if (excep_flush_i) begin
         cancel_cnt_next_s = outst_cnt_next_s;
      end else if (cancel_inc_s && !cancel_dec_s) begin
         cancel_cnt_next_s = cancel_cnt_r + 2'd1;
      end else if (!cancel_inc_s && cancel_dec_s) begin
         cancel_cnt_next_s = cancel_cnt_r - 2'd1;
      end else begin
         cancel_cnt_next_s = cancel_cnt_r;
      end
   end

   // Response routing: buffered data always goes ahead of live rdata.
   always_comb begin
      push_s      = 1'b0;
      rsp_valid_s = 1'b0;
      rsp_rdata_s = '0;
`ifdef DCACHE_RSP_BYPASS_EN
      push_s      = keep_s && (buf_nonempty_s || !wb_allowin_i);
      rsp_valid_s = (buf_nonempty_s || keep_s) && !excep_flush_i;
      if (buf_nonempty_s) begin
         rsp_rdata_s = buf_mem_r[rd_ptr_r];
      end else if (keep_s) begin
         rsp_rdata_s = rdata_i;
      end else begin
         rsp_rdata_s = '0;
      end
`else
      push_s      = keep_s;
      rsp_valid_s = buf_nonempty_s && !excep_flush_i;
      if (buf_nonempty_s) begin
         rsp_rdata_s = buf_mem_r[rd_ptr_r];
      end else begin
         rsp_rdata_s = '0;
      end
`endif
   end

   assign mem_allowin_o = allowin_s;
   assign rsp_valid_o   = rsp_valid_s;
   assign rsp_rdata_o   = rsp_rdata_s;
   assign req_o         = req_r;
   assign wr_o          = wr_r;
   assign size_o        = size_r;
   assign wstrb_o       = wstrb_r;
   assign addr_o        = addr_r;
   assign wdata_o       = wdata_r;

   // FSM state, bus request fields and transaction counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         req_r        <= 1'b0;
         wr_r         <= 1'b0;
         size_r       <= 2'd0;
         wstrb_r      <= 4'd0;
         addr_r       <= '0;
         wdata_r      <= '0;
         outst_cnt_r  <= 2'd0;
         cancel_cnt_r <= 2'd0;
      end else begin
         state_r      <= state_next_s;
         req_r        <= (state_next_s != IDLE);
         outst_cnt_r  <= outst_cnt_next_s;
         cancel_cnt_r <= cancel_cnt_next_s;
         if (accept_s) begin
            wr_r    <= ex_wr_i;
            size_r  <= ex_size_i;
            wstrb_r <= ex_wstrb_i;
            addr_r  <= ex_addr_i;
            wdata_r <= ex_wdata_i;
         end
      end
   end

   // Response buffer pointers and occupancy; a flush empties it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_r  <= 2'd0;
         wr_ptr_r  <= 2'd0;
         buf_cnt_r <= 2'd0;
      end else if (excep_flush_i) begin
         rd_ptr_r  <= 2'd0;
         wr_ptr_r  <= 2'd0;
         buf_cnt_r <= 2'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   buf_cnt_r <= buf_cnt_r + 2'd1;
            2'b01:   buf_cnt_r <= buf_cnt_r - 2'd1;
            default: buf_cnt_r <= buf_cnt_r;
         endcase
      end
   end

   // Response buffer data storage.
   always_ff @(posedge clk) begin
      if (push_s) begin
         buf_mem_r[wr_ptr_r] <= rdata_i;
      end
   end

   dcache_req_port_chk #(.MAX_OUTST(MAX_OUTST)) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .hs         (hs_s),
      .data_ok    (data_ok_i),
      .outst_cnt  (outst_cnt_r),
      .cancel_cnt (cancel_cnt_r),
      .buf_cnt    (buf_cnt_r)
   );

endmodule

// File: tb/tb_dcache_req_port.sv
// Self-checking bench for dcache_req_port: scripted cycle-by-cycle scenarios
// plus a scoreboard of expected in-order responses consumed by WB.
module tb_dcache_req_port;
   localparam int MAX_OUTST = 2;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
`ifdef DCACHE_RSP_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              ex_valid_i, ex_wr_i;
   logic [1:0]        ex_size_i;
   logic [3:0]        ex_wstrb_i;
   logic [ADDR_W-1:0] ex_addr_i;
   logic [DATA_W-1:0] ex_wdata_i;
   logic              mem_allowin_o;
   logic              req_o, wr_o;
   logic [1:0]        size_o;
   logic [3:0]        wstrb_o;
   logic [ADDR_W-1:0] addr_o;
   logic [DATA_W-1:0] wdata_o;
   logic              addr_ok_i, data_ok_i;
   logic [DATA_W-1:0] rdata_i;
   logic              excep_flush_i, wb_allowin_i;
   logic              rsp_valid_o;
   logic [DATA_W-1:0] rsp_rdata_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] mon_exp;

   dcache_req_port #(.MAX_OUTST(MAX_OUTST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid_i(ex_valid_i), .ex_wr_i(ex_wr_i), .ex_size_i(ex_size_i),
      .ex_wstrb_i(ex_wstrb_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
      .mem_allowin_o(mem_allowin_o),
      .req_o(req_o), .wr_o(wr_o), .size_o(size_o), .wstrb_o(wstrb_o),
      .addr_o(addr_o), .wdata_o(wdata_o),
      .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .rdata_i(rdata_i),
      .excep_flush_i(excep_flush_i), .wb_allowin_i(wb_allowin_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   // Scoreboard: every response WB consumes must be the next expected one.
   always @(negedge clk) begin
      if (rst_n && rsp_valid_o && wb_allowin_i) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got response %h, expected none", rsp_rdata_o);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rsp_rdata_o !== mon_exp) begin
               n_fail++;
               $display("FAIL sb_data: got %h, expected %h", rsp_rdata_o, mon_exp);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clr();
      ex_valid_i = 1'b0; ex_wr_i = 1'b0; ex_size_i = 2'd2; ex_wstrb_i = 4'hF;
      ex_addr_i = 32'h0; ex_wdata_i = 32'h0;
      addr_ok_i = 1'b0; data_ok_i = 1'b0; rdata_i = 32'h0;
      excep_flush_i = 1'b0; wb_allowin_i = 1'b1;
   endtask

   task automatic ex_load(input logic [31:0] a);
      ex_valid_i = 1'b1; ex_wr_i = 1'b0; ex_addr_i = a;
   endtask

   task automatic drain_check(input string name);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d responses still expected, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      clr(); rst_n = 1'b0;
      cyc(); cyc(); settle();
      n_checks++;
      if ({req_o, wr_o, size_o, wstrb_o, rsp_valid_o, mem_allowin_o} !== 10'd0 ||
          addr_o !== 32'h0 || wdata_o !== 32'h0 || rsp_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b wr=%b size=%h wstrb=%h addr=%h wdata=%h v=%b rd=%h allow=%b, expected all 0",
                  req_o, wr_o, size_o, wstrb_o, addr_o, wdata_o, rsp_valid_o, rsp_rdata_o, mem_allowin_o);
      end
      cyc(); rst_n = 1'b1; settle();
      n_checks++;
      if (mem_allowin_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_allowin: got %b, expected 1", mem_allowin_o);
      end
   endtask

   task automatic test_load();
      cyc(); clr(); ex_load(32'h1000); settle();
      n_checks++;
      if (mem_allowin_o !== 1'b1) begin n_fail++; $display("FAIL load_allowin: got %b, expected 1", mem_allowin_o); end
      cyc(); clr(); addr_ok_i = 1'b1; settle();
      n_checks++;
      if (req_o !== 1'b1 || addr_o !== 32'h1000 || wr_o !== 1'b0 || size_o !== 2'd2) begin
         n_fail++; $display("FAIL load_req: req=%b addr=%h wr=%b size=%h, expected 1/00001000/0/2", req_o, addr_o, wr_o, size_o);
      end
      cyc(); clr(); settle();
      n_checks++;
      if (req_o !== 1'b0) begin n_fail++; $display("FAIL load_req_drop: got %b, expected 0", req_o); end
      cyc(); clr(); data_ok_i = 1'b1; rdata_i = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF); settle();
      n_checks++;
      if (rsp_valid_o !== BYP) begin n_fail++; $display("FAIL load_rsp_c3: got %b, expected %b", rsp_valid_o, BYP); end
      cyc(); clr(); settle();
      n_checks++;
      if (rsp_valid_o !== !BYP) begin n_fail++; $display("FAIL load_rsp_c4: got %b, expected %b", rsp_valid_o, !BYP); end
      cyc(); clr(); settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0 || mem_allowin_o !== 1'b1) begin
         n_fail++; $display("FAIL load_idle: valid=%b allow=%b, expected 0/1", rsp_valid_o, mem_allowin_o);
      end
      drain_check("load");
   endtask

   task automatic test_buffer();
      cyc(); clr(); wb_allowin_i = 1'b0; ex_load(32'h2000);
      cyc(); clr(); wb_allowin_i = 1'b0; addr_ok_i = 1'b1;
      cyc(); clr(); wb_allowin_i = 1'b0; ex_load(32'h2004);
      cyc(); clr(); wb_allowin_i = 1'b0; addr_ok_i = 1'b1;
      cyc(); clr(); wb_allowin_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h11; exp_q.push_back(32'h11); settle();
      n_checks++;
      if (mem_allowin_o !== 1'b0) begin n_fail++; $display("FAIL buf_allowin_full: got %b, expected 0", mem_allowin_o); end
      cyc(); clr(); wb_allowin_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h22; exp_q.push_back(32'h22); settle();
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h11) begin
         n_fail++; $display("FAIL buf_head: valid=%b data=%h, expected 1/00000011", rsp_valid_o, rsp_rdata_o);
      end
      cyc(); clr(); settle();
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h11 || mem_allowin_o !== 1'b0) begin
         n_fail++; $display("FAIL buf_pop1: valid=%b data=%h allow=%b, expected 1/00000011/0", rsp_valid_o, rsp_rdata_o, mem_allowin_o);
      end
      cyc(); clr(); settle();
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h22) begin
         n_fail++; $display("FAIL buf_pop2: valid=%b data=%h, expected 1/00000022", rsp_valid_o, rsp_rdata_o);
      end
      cyc(); clr(); settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0 || mem_allowin_o !== 1'b1) begin
         n_fail++; $display("FAIL buf_empty: valid=%b allow=%b, expected 0/1", rsp_valid_o, mem_allowin_o);
      end
      drain_check("buffer");
   endtask

   task automatic test_flush_outstanding();
      cyc(); clr(); ex_load(32'h3000);
      cyc(); clr(); addr_ok_i = 1'b1;
      cyc(); clr(); ex_load(32'h3004);
      cyc(); clr(); addr_ok_i = 1'b1;
      cyc(); clr(); excep_flush_i = 1'b1; settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL flo_flush_cycle: got %b, expected 0", rsp_valid_o); end
      cyc(); clr();
      for (int i = 0; i < 2; i++) begin
         cyc(); clr(); data_ok_i = 1'b1; rdata_i = 32'hBAD0_0001 + i; settle();
         n_checks++;
         if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL flo_drop%0d: got %b, expected 0", i, rsp_valid_o); end
      end
      cyc(); clr(); ex_load(32'h3008); settle();
      n_checks++;
      if (mem_allowin_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL flo_after: allow=%b valid=%b, expected 1/0", mem_allowin_o, rsp_valid_o);
      end
      cyc(); clr(); addr_ok_i = 1'b1;
      cyc(); clr(); data_ok_i = 1'b1; rdata_i = 32'h33; exp_q.push_back(32'h33); settle();
      n_checks++;
      if (rsp_valid_o !== BYP) begin n_fail++; $display("FAIL flo_third_rsp: got %b, expected %b", rsp_valid_o, BYP); end
      cyc(); clr(); cyc(); clr();
      drain_check("flush_outst");
   endtask

   task automatic test_flush_in_req();
      cyc(); clr(); ex_valid_i = 1'b1; ex_wr_i = 1'b1; ex_size_i = 2'd1; ex_wstrb_i = 4'h3;
      ex_addr_i = 32'h4000; ex_wdata_i = 32'h5555AAAA;
      cyc(); clr(); excep_flush_i = 1'b1; settle();
      n_checks++;
      if (req_o !== 1'b1 || rsp_valid_o !== 1'b0 || mem_allowin_o !== 1'b0) begin
         n_fail++; $display("FAIL fir_flush: req=%b valid=%b allow=%b, expected 1/0/0", req_o, rsp_valid_o, mem_allowin_o);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(); clr(); ex_load(32'h4444); settle();
         n_checks++;
         if (req_o !== 1'b1 || addr_o !== 32'h4000 || wdata_o !== 32'h5555AAAA || wr_o !== 1'b1 ||
             size_o !== 2'd1 || wstrb_o !== 4'h3 || mem_allowin_o !== 1'b0) begin
            n_fail++; $display("FAIL fir_hold%0d: req=%b addr=%h wdata=%h wr=%b size=%h wstrb=%h allow=%b, expected 1/00004000/5555aaaa/1/1/3/0",
                               i, req_o, addr_o, wdata_o, wr_o, size_o, wstrb_o, mem_allowin_o);
         end
      end
      cyc(); clr(); addr_ok_i = 1'b1; settle();
      n_checks++;
      if (req_o !== 1'b1 || addr_o !== 32'h4000) begin
         n_fail++; $display("FAIL fir_hs: req=%b addr=%h, expected 1/00004000", req_o, addr_o);
      end
      cyc(); clr(); settle();
      n_checks++;
      if (req_o !== 1'b0 || mem_allowin_o !== 1'b1) begin
         n_fail++; $display("FAIL fir_idle: req=%b allow=%b, expected 0/1", req_o, mem_allowin_o);
      end
      cyc(); clr(); data_ok_i = 1'b1; rdata_i = 32'hBAD00005; settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL fir_drop: got %b, expected 0", rsp_valid_o); end
      cyc(); clr(); settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL fir_drop_late: got %b, expected 0", rsp_valid_o); end
      drain_check("flush_req");
   endtask

   task automatic test_flush_with_data_ok();
      cyc(); clr(); ex_load(32'h5000);
      cyc(); clr(); addr_ok_i = 1'b1;
      cyc(); clr(); ex_load(32'h5004);
      cyc(); clr(); addr_ok_i = 1'b1;
      cyc(); clr(); excep_flush_i = 1'b1; data_ok_i = 1'b1; rdata_i = 32'hBAD00003; settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL fwd_same: got %b, expected 0", rsp_valid_o); end
      cyc(); clr(); data_ok_i = 1'b1; rdata_i = 32'hBAD00004; settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL fwd_next: got %b, expected 0", rsp_valid_o); end
      cyc(); clr(); ex_load(32'h5008); settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0 || mem_allowin_o !== 1'b1) begin
         n_fail++; $display("FAIL fwd_empty: valid=%b allow=%b, expected 0/1", rsp_valid_o, mem_allowin_o);
      end
      cyc(); clr(); addr_ok_i = 1'b1;
      cyc(); clr(); data_ok_i = 1'b1; rdata_i = 32'h44; exp_q.push_back(32'h44);
      cyc(); clr(); cyc(); clr();
      drain_check("flush_dok");
   endtask

   task automatic test_flush_buffer();
      cyc(); clr(); wb_allowin_i = 1'b0; ex_load(32'h7000);
      cyc(); clr(); wb_allowin_i = 1'b0; addr_ok_i = 1'b1;
      cyc(); clr(); wb_allowin_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h55;
      cyc(); clr(); wb_allowin_i = 1'b0; excep_flush_i = 1'b1;
      cyc(); clr(); settle();
      n_checks++;
      if (rsp_valid_o !== 1'b0 || mem_allowin_o !== 1'b1) begin
         n_fail++; $display("FAIL fbuf_cleared: valid=%b allow=%b, expected 0/1", rsp_valid_o, mem_allowin_o);
      end
      drain_check("flush_buf");
   endtask

   task automatic test_reset_mid();
      cyc(); clr(); wb_allowin_i = 1'b0; ex_load(32'h6000);
      cyc(); clr(); wb_allowin_i = 1'b0; addr_ok_i = 1'b1;
      cyc(); clr(); wb_allowin_i = 1'b0; ex_load(32'h6004);
      cyc(); clr(); wb_allowin_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h77;
      cyc(); clr(); wb_allowin_i = 1'b0; rst_n = 1'b0; settle();
      n_checks++;
      if (req_o !== 1'b1 || rsp_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL rmid_pre: req=%b valid=%b, expected 1/1", req_o, rsp_valid_o);
      end
      cyc(); clr(); rst_n = 1'b0; settle();
      n_checks++;
      if ({req_o, wr_o, size_o, wstrb_o, rsp_valid_o, mem_allowin_o} !== 10'd0 ||
          addr_o !== 32'h0 || wdata_o !== 32'h0 || rsp_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL rmid_reset: req=%b addr=%h valid=%b rd=%h allow=%b, expected all 0",
                  req_o, addr_o, rsp_valid_o, rsp_rdata_o, mem_allowin_o);
      end
      cyc(); clr(); rst_n = 1'b1; ex_load(32'h6008); settle();
      n_checks++;
      if (mem_allowin_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL rmid_after: allow=%b valid=%b, expected 1/0", mem_allowin_o, rsp_valid_o);
      end
      cyc(); clr(); addr_ok_i = 1'b1;
      cyc(); clr(); data_ok_i = 1'b1; rdata_i = 32'h88; exp_q.push_back(32'h88);
      cyc(); clr(); cyc(); clr();
      drain_check("reset_mid");
   endtask

   initial begin
      clr();
      rst_n = 1'b0;
      test_reset();
      test_load();
      test_buffer();
      test_flush_outstanding();
      test_flush_in_req();
      test_flush_with_data_ok();
      test_flush_buffer();
      test_reset_mid();
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
